// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, control opcodes
// and the bit layout of a 16-bit instruction word.
package fetch_sequencer_pkg;

    localparam int ADDR_W  = 3;
    localparam int INSTR_W = 16;

    localparam int OPC_LSB = 12;
    localparam int OPC_W   = 4;
    localparam int RD_LSB  = 9;
    localparam int RD_W    = 3;
    localparam int RS_LSB  = 6;
    localparam int RS_W    = 3;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 6;

    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hE;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DECODE,
        ISSUE,
        HALTED
    } state_t;

endpackage

// File: rtl/fetch_sequencer_instr_field_split.sv
// Purely combinational split of an instruction word into opcode/rd/rs/imm.
module instr_field_split
    import fetch_sequencer_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [RD_W-1:0]    rd,
    output logic [RS_W-1:0]    rs,
    output logic [IMM_W-1:0]   imm
);

    assign opcode = instr[OPC_LSB +: OPC_W];
    assign rd     = instr[RD_LSB  +: RD_W];
    assign rs     = instr[RS_LSB  +: RS_W];
    assign imm    = instr[IMM_LSB +: IMM_W];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/issue sequencer: reads program memory at pc,
// resolves HALT and JMP locally and hands other instructions to execute.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int n = 16,
    parameter int m = 8
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic              mem_ready,
    input  logic [n-1:0]      mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_status_ok,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [OPC_W-1:0]  opcode,
    output logic [RD_W-1:0]   rd,
    output logic [RS_W-1:0]   rs,
    output logic [IMM_W-1:0]  imm,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [n-1:0]        instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_inc;

    instr_field_split u_split (
        .instr  (instr_q[INSTR_W-1:0]),
        .opcode (opcode),
        .rd     (rd),
        .rs     (rs),
        .imm    (imm)
    );

    // Wraps at the last program word, so depth 8 gives 7 + 1 = 0.
    assign pc_inc = (pc_q == ADDR_W'(m - 1)) ? '0 : pc_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    instr_d = mem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = HALTED;
                end else if (opcode == OP_JMP) begin
                    // Jump target comes from the low immediate bits; never issued.
                    pc_d    = imm[ADDR_W-1:0];
                    state_d = FETCH;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr      = addr_q;
    assign pc            = pc_q;
    assign instr_valid   = (state_q == ISSUE);
    assign halted        = (state_q == HALTED);
    assign mem_status_ok = (state_q == FETCH) || (state_q == WAIT) ||
                           (state_q == DECODE) || (state_q == ISSUE);

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter n, default 16, meaning instruction/data word width in bits.
REQ-002 Parameter m, default 8, meaning program memory depth in words; address width fixed at 3.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clear_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  begin execution; sampled only in IDLE or HALTED.
REQ-006 mem_ready  input  1  program memory ready flag; mem_data is valid while high.
REQ-007 mem_data  input  n  instruction word returned by program memory.
REQ-008 mem_addr  output  3  read address to program memory, registered.
REQ-009 mem_status_ok  output  1  read-enable to program memory.
REQ-010 instr_valid  output  1  decoded instruction available to the execute stage.
REQ-011 instr_ready  input  1  execute stage accepts the instruction.
REQ-012 opcode  output  4  instruction bits [15:12].
REQ-013 rd  output  3  instruction bits [11:9].
REQ-014 rs  output  3  instruction bits [8:6].
REQ-015 imm  output  6  instruction bits [5:0].
REQ-016 pc  output  3  current program counter.
REQ-017 halted  output  1  high while in HALTED.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, WAIT, DECODE, ISSUE, HALTED.
REQ-019 IDLE: mem_status_ok=0; start=1 -> pc=0, next FETCH.
REQ-020 FETCH: lasts exactly 1 cycle; mem_addr equals pc and stays stable; next WAIT.
REQ-021 WAIT: if mem_ready=1 at the clock edge, capture mem_data into the instruction register and go to DECODE; else remain in WAIT indefinitely.
REQ-022 DECODE: opcode 4'hF -> HALTED; opcode 4'hE (JMP) -> pc=imm[2:0], FETCH, not issued; any other opcode -> ISSUE.
REQ-023 ISSUE: instr_valid=1; on instr_ready=1, pc=pc+1 and next FETCH.
REQ-024 HALTED: halted=1, mem_status_ok=0; start=1 -> pc=0, next FETCH.
REQ-025 mem_status_ok SHALL be 1 in FETCH, WAIT, DECODE and ISSUE.
REQ-026 mem_addr SHALL be a registered copy of pc, updated in the same edge that changes pc.
REQ-027 pc increment SHALL be modulo 8: 3'd7 + 1 = 3'd0.
REQ-028 opcode, rd, rs and imm SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-029 Latency SHALL be: start sampled at edge k -> instr_valid high in cycle k+4 when mem_ready is already 1; minimum 4 cycles per issued instruction.
REQ-030 start outside IDLE/HALTED, and instr_ready outside ISSUE, SHALL be ignored.
REQ-031 JMP to its own address SHALL loop with no instr_valid pulses and no error.
REQ-032 mem_ready dropping during FETCH/WAIT (memory being reloaded) SHALL stall in WAIT with no capture.

Reset
REQ-033 clear_n=0 SHALL asynchronously force state=IDLE, pc=0, mem_addr=0, mem_status_ok=0, instr_valid=0, halted=0, and opcode/rd/rs/imm=0.
REQ-034 Reset asserted mid-operation SHALL abort any pending issue; no instr_valid SHALL appear until a new start.
REQ-035 Release of clear_n SHALL take effect on the next rising clk edge.

Structure
REQ-036 A shared package SHALL hold the state enumeration, the opcode constants (OP_HALT=4'hF, OP_JMP=4'hE) and the field bit positions/widths.
REQ-037 Field extraction SHALL be one combinational sub-module, instr_field_split, instantiated once on the instruction register; everything else stays in fetch_sequencer.

Verification
REQ-038 Reset then start, memory[0]=16'h1234, instr_ready=1 -> instr_valid in cycle 4; opcode=1, rd=1, rs=0, imm=6'h34; pc advances to 1.
REQ-039 memory[0]=16'hE005 (JMP 5), memory[5]=16'hF000 -> no instr_valid pulse; mem_addr sequence 0,5; halted=1; mem_status_ok=0.
REQ-040 instr_ready held 0 for 10 cycles in ISSUE with memory[2]=16'h2A4F -> outputs constant for all 10 cycles; a single accept then advances pc 2->3.
REQ-041 Eight non-control instructions at addresses 0..7, instr_ready=1 -> eight issues; pc wraps 7->0 and memory[0] is fetched again.
REQ-042 mem_ready held 0 for 5 cycles during WAIT -> FSM stays in WAIT, no capture; capture occurs on the first edge with mem_ready=1.
REQ-043 clear_n pulsed low during ISSUE at pc=3 -> instr_valid=0 and pc=0 immediately (asynchronously); no activity until start.
